uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
UART receive path: recovers LSB-first frames from the serial line and presents parallel data plus error flags.
- clk is the oversampling clock, equal to Prescale × baud rate; ARSTn is the system reset.
- Frame format: start(0), DATA_WIDTH data bits, optional parity, stop(1).
- Paired with the TX serializer: consumes exactly the frame the TX path produces and feeds the RX-side data synchronizer / register file.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_WIDTH, 6, width of the Prescale input (supports 8/16/32).

Ports:
clk  input  1  oversampling clock
ARSTn  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = parity bit present in frame
PAR_TYP  input  1  0 = even, 1 = odd
Prescale  input  PRESCALE_WIDTH  oversampling ratio: 8, 16 or 32
P_DATA  output  DATA_WIDTH  last good received word
data_valid  output  1  one-cycle pulse, new good word on P_DATA
par_err  output  1  one-cycle pulse, parity mismatch
stp_err  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0, FSM=IDLE, edge_cnt=0, bit_cnt=0.
- ARSTn low mid-frame aborts the frame immediately. After release, the block waits in IDLE for a falling edge, with no partial-frame output.
- Prescale latching: Prescale is latched on entry to START. Any value other than 8/16/32 is treated as 8. Changing Prescale mid-frame has no effect.
- edge_cnt: counts 0..Prescale-1 within each bit, then wraps to 0 and advances the bit.
- Sampling: RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: stays while RX_IN=1. RX_IN=0 → START with edge_cnt=0.
- START: at edge_cnt=P-1, sampled bit 0 → DATA; sampled bit 1 (glitch) → IDLE, no flags raised.
- DATA: shift register fills LSB first. After DATA_WIDTH bits, go to PARITY if PAR_EN=1, else STOP.
- PARITY: expected parity is XOR(data) for even, ~XOR(data) for odd. The mismatch result is held until end of STOP.
- STOP: at edge_cnt=P-1 evaluate the frame:
  - sampled stop=0 → stp_err=1;
  - parity mismatch → par_err=1 (both flags may assert together);
  - no error → P_DATA loaded and data_valid=1;
  - any error → P_DATA unchanged, data_valid=0.
- Output timing: all three outputs are registered and high for exactly one clk, in the cycle after the STOP evaluation edge.
- Back-to-back frames: on STOP exit, RX_IN=0 → direct to START (edge_cnt=0); otherwise → IDLE. Zero idle bits between frames is supported.
- PAR_EN/PAR_TYP: latched on entry to START.
- Latency: data_valid asserts (1 + DATA_WIDTH + PAR_EN + 1)×P clk cycles after the start-bit falling edge, +1 registered-output cycle.

Optional Feature:
RX_SYNC_EN:
- Defined: RX_IN passes through a 2-flop synchronizer, reset to 1, before the FSM. All timing is shifted +2 clk, and the flops reset to idle-high so reset never creates a false start.
- Undefined: RX_IN feeds the FSM directly. The driver must be synchronous to clk.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 → P_DATA=0xA5; data_valid one pulse at 80 clk after the falling edge (+1); par_err=stp_err=0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 1 (wrong; correct is 0) → par_err pulse, data_valid=0, P_DATA keeps previous value.
- Prescale=32, odd parity, 0x00 with stop bit 0 → stp_err pulse only, no data_valid.
- Start glitch: RX_IN low for 2 clk at Prescale=8 → FSM back to IDLE, no outputs; a following valid frame 0x5A is received correctly.
- Back-to-back: frames 0x11, 0xEE with zero idle gap at Prescale=16 → two data_valid pulses 160 clk apart (PAR_EN=0), values in order.
- ARSTn asserted during DATA bit 4 → all outputs 0; after release a clean frame 0x81 → P_DATA=0x81, data_valid pulse.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver for LSB-first frames with optional parity.
// Define RX_SYNC_EN to put a 2-flop synchronizer on RX_IN (adds 2 clk of latency).
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      ARSTn,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      par_bad_q, par_bad_d;
    logic [2:0]                samp_q, samp_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      dv_q, dv_d;
    logic                      pe_q, pe_d;
    logic                      se_q, se_d;

    logic                      rx;
    logic [PRESCALE_WIDTH-1:0] prescale_sel;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      bit_end;
    logic                      in_window;
    logic                      bit_val;
    logic                      start_frame;

`ifdef RX_SYNC_EN
    logic [1:0] rx_sync_q;

    // Reset to idle-high so leaving reset can never look like a start bit.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RX_IN};
        end
    end

    assign rx = rx_sync_q[1];
`else
    assign rx = RX_IN;
`endif

    // Unsupported ratios fall back to 8.
    always_comb begin
        prescale_sel = PRESCALE_WIDTH'(8);
        if (Prescale == PRESCALE_WIDTH'(16) || Prescale == PRESCALE_WIDTH'(32)) begin
            prescale_sel = Prescale;
        end
    end

    assign half      = presc_q >> 1;
    assign bit_end   = (edge_cnt_q == presc_q - 1'b1);
    assign in_window = (edge_cnt_q == half - 1'b1) || (edge_cnt_q == half) ||
                       (edge_cnt_q == half + 1'b1);
    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        presc_d     = presc_q;
        bit_cnt_d   = bit_cnt_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        par_bad_d   = par_bad_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;
        start_frame = 1'b0;

        if (state_q != StIdle) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + 1'b1;
            if (in_window) begin
                samp_d = {samp_q[1:0], rx};
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!rx) begin
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    if (bit_val) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    // Mismatch = received bit differs from XOR(data) (inverted for odd).
                    par_bad_d = bit_val ^ (^shift_q) ^ par_typ_q;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    se_d = ~bit_val;
                    pe_d = par_bad_q;
                    if (bit_val && !par_bad_q) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
                    if (!rx) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Frame configuration is captured once per frame, at the start bit.
        if (start_frame) begin
            state_d    = StStart;
            edge_cnt_d = '0;
            presc_d    = prescale_sel;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            par_bad_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            presc_q    <= PRESCALE_WIDTH'(8);
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            samp_q     <= '1;
            shift_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            presc_q    <= presc_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

`ifndef SYNTHESIS
    // A good word and an error flag describe different frames, never the same one.
    valid_excludes_err: assert property (@(posedge clk) disable iff (!ARSTn)
        !(data_valid && (par_err || stp_err)));
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer: scoreboard of expected output events, checked
// by a negedge monitor; scenario tasks drive frames and check drain/hold behaviour.
module tb_uart_rx_deserializer;

    localparam int DW = 8;
`ifdef RX_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic          clk      = 1'b0;
    logic          ARSTn    = 1'b0;
    logic          RX_IN    = 1'b1;
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic [5:0]    Prescale = 6'd8;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    typedef struct {
        logic [DW-1:0] data;
        logic          dv;
        logic          pe;
        logic          se;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks      = 0;
    int            errors      = 0;
    int            cyc         = 0;
    int            ev_cnt      = 0;
    logic [DW-1:0] model_pdata = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(6)
    ) dut (
        .clk       (clk),
        .ARSTn     (ARSTn),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    // Every cycle with any output pulse consumes exactly one expected event.
    always @(negedge clk) begin
        if (ARSTn && (data_valid || par_err || stp_err)) begin
            ev_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event dv/pe/se=%b%b%b data=%h cyc=%0d required=none",
                         data_valid, par_err, stp_err, P_DATA, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({data_valid, par_err, stp_err} !== {mon_e.dv, mon_e.pe, mon_e.se}) begin
                    errors++;
                    $display("FAIL event_flags dv/pe/se=%b%b%b required=%b%b%b",
                             data_valid, par_err, stp_err, mon_e.dv, mon_e.pe, mon_e.se);
                end
                checks++;
                if (P_DATA !== mon_e.data) begin
                    errors++;
                    $display("FAIL event_data P_DATA=%h required=%h", P_DATA, mon_e.data);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL event_timing cyc=%0d required=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Push the expected event, then drive one frame; returns #1 after the last bit's final edge.
    task automatic frame(input logic [DW-1:0] d, input logic [5:0] pv, input logic pen,
                         input logic ptyp, input logic pbit, input logic sbit,
                         input logic wiggle);
        int   p;
        logic pe;
        logic se;
        exp_t e;
        p  = (pv == 6'd16 || pv == 6'd32) ? int'(pv) : 8;
        pe = pen && (pbit != ((^d) ^ ptyp));
        se = !sbit;
        if (!pe && !se) model_pdata = d;
        e.data = model_pdata;
        e.dv   = !pe && !se;
        e.pe   = pe;
        e.se   = se;
        e.cyc  = cyc + (2 + DW + int'(pen)) * p + 1 + SyncLat;
        exp_q.push_back(e);
        Prescale = pv;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        repeat (p) @(posedge clk);
        #1;
        if (wiggle) begin
            Prescale = 6'd32;
            PAR_EN   = !pen;
            PAR_TYP  = !ptyp;
        end
        for (int i = 0; i < DW; i++) begin
            RX_IN = d[i];
            repeat (p) @(posedge clk);
            #1;
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p) @(posedge clk);
            #1;
        end
        RX_IN = sbit;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ARSTn = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({P_DATA, data_valid, par_err, stp_err} !== '0) begin
            errors++;
            $display("FAIL reset_values P_DATA=%h dv/pe/se=%b%b%b required=0 000",
                     P_DATA, data_valid, par_err, stp_err);
        end
        align();
        ARSTn = 1'b1;
        repeat (10) align();
        checks++;
        if ({P_DATA, data_valid, par_err, stp_err} !== '0) begin
            errors++;
            $display("FAIL reset_idle P_DATA=%h dv/pe/se=%b%b%b required=0 000",
                     P_DATA, data_valid, par_err, stp_err);
        end
    endtask

    task automatic test_basic();
        frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        RX_IN = 1'b1;
        repeat (5) align();
        frame(8'h37, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        RX_IN = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (P_DATA !== 8'h37) begin
            errors++;
            $display("FAIL basic_pdata P_DATA=%h required=37", P_DATA);
        end
        align();
    endtask

    task automatic test_errors();
        frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        RX_IN = 1'b1;
        repeat (5) align();
        frame(8'h00, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        RX_IN = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL errors_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (P_DATA !== 8'h37) begin
            errors++;
            $display("FAIL errors_hold P_DATA=%h required=37", P_DATA);
        end
        align();
    endtask

    task automatic test_glitch();
        int ev0;
        ev0      = ev_cnt;
        Prescale = 6'd8;
        RX_IN    = 1'b0;
        repeat (2) align();
        RX_IN = 1'b1;
        repeat (30) align();
        checks++;
        if (ev_cnt != ev0) begin
            errors++;
            $display("FAIL glitch_quiet events=%0d required=%0d", ev_cnt, ev0);
        end
        frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        RX_IN = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        align();
    endtask

    task automatic test_back_to_back();
        frame(8'h11, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(8'hEE, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        RX_IN = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (P_DATA !== 8'hEE) begin
            errors++;
            $display("FAIL b2b_pdata P_DATA=%h required=ee", P_DATA);
        end
        align();
    endtask

    task automatic test_config_latch();
        // Invalid ratio 20 acts as 8; mid-frame config changes must be ignored.
        frame(8'hC3, 6'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        RX_IN = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL latch_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        align();
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        int            ev0;
        d        = 8'h96;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) align();
        for (int i = 0; i < 4; i++) begin
            RX_IN = d[i];
            repeat (8) align();
        end
        RX_IN = d[4];
        repeat (4) align();
        ARSTn       = 1'b0;
        RX_IN       = 1'b1;
        model_pdata = '0;
        @(negedge clk);
        checks++;
        if ({P_DATA, data_valid, par_err, stp_err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs P_DATA=%h dv/pe/se=%b%b%b required=0 000",
                     P_DATA, data_valid, par_err, stp_err);
        end
        repeat (3) align();
        ARSTn = 1'b1;
        ev0   = ev_cnt;
        repeat (40) align();
        checks++;
        if (ev_cnt != ev0) begin
            errors++;
            $display("FAIL midreset_quiet events=%0d required=%0d", ev_cnt, ev0);
        end
        frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        RX_IN = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (P_DATA !== 8'h81) begin
            errors++;
            $display("FAIL midreset_pdata P_DATA=%h required=81", P_DATA);
        end
        align();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_glitch();
        test_back_to_back();
        test_config_latch();
        test_reset_mid_frame();
        repeat (20) align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
